hazard_unit_mc: RTL and testbench

Parametrised next-generation hazard unit for the pipelined RISC-V core. It adds long-latency support on top of GPR/CSR forwarding and load-use stalling:
- a sequential scoreboard and countdown for one multi-cycle execute unit (divider);
- an instruction/data cache-miss stall state machine;
- a saturating stall-cycle performance counter.

It sits beside the datapath and drives all stage stall/flush and EX-stage forward selects.

---
 rtl/hazard_unit_mc_pkg.sv | 13 +
 rtl/hazard_unit_mc_scoreboard.sv | 54 +++++
 rtl/hazard_unit_mc.sv | 137 +++++++++++++
 tb/tb_hazard_unit_mc.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_mc_pkg.sv
// Shared hazard-unit encodings: EX result source, forward select values, miss FSM states.
package hazard_unit_mc_pkg;

  localparam logic [2:0] RESULT_MEM_DATA = 3'd1;
  localparam int         NO_FORWARD      = 0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IC_WAIT = 2'd1,
    DC_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_unit_mc_scoreboard.sv
// Multi-cycle unit tracker: per-register busy bits, latency countdown, busy/done flags.
// Done is held while the writeback stage is stalled and fires on the first free cycle.
module hazard_unit_mc_scoreboard
  import hazard_unit_mc_pkg::*;
#(
  parameter int MC_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  start_rd,
  input  logic        hold,
  output logic [31:0] regs,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(MC_LAT);

  logic [CW-1:0] count;
  logic          pending;
  logic [4:0]    op_rd;
  logic [31:0]   regs_next;

  assign busy = start | (count != '0);
  assign done = pending & (count == '0) & ~hold;

  always_comb begin
    regs_next = regs;
    if (done) regs_next[op_rd] = 1'b0;
    // x0 is never tracked so it can never cause a dependency stall
    if (start && start_rd != 5'd0) regs_next[start_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      pending <= 1'b0;
      op_rd   <= 5'd0;
      regs    <= '0;
    end else begin
      if (start) begin
        count <= CW'(MC_LAT - 1);
        op_rd <= start_rd;
      end else if (count != '0) begin
        count <= count - CW'(1);
      end
      if (start) pending <= 1'b1;
      else if (done) pending <= 1'b0;
      regs <= regs_next;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit: GPR/CSR forwarding, load-use and multi-cycle stalls, cache-miss FSM, stall counter.
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int FWD_W   = $clog2(NUM_FWD + 1),
  parameter int MC_LAT  = 8,
  parameter int CNT_W   = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  instr_hit_fi_i,
  input  logic                  ic_repl_permit_i,
  input  logic                  dc_miss_mem_i,
  input  logic                  dc_ready_i,
  input  logic [4:0]            rs1_de_i,
  input  logic [4:0]            rs2_de_i,
  input  logic [4:0]            rd_de_i,
  input  logic [4:0]            rs1_ex_i,
  input  logic [4:0]            rs2_ex_i,
  input  logic [4:0]            rd_ex_i,
  input  logic [2:0]            result_src_ex_i,
  input  logic                  mc_start_ex_i,
  input  logic [11:0]           csr_addr_ex_i,
  input  logic [1:0]            pc_src_i,
  input  logic [1:0]            pc_src_reg_i,
  input  logic [NUM_FWD*5-1:0]  rd_fwd_i,
  input  logic [NUM_FWD-1:0]    reg_write_fwd_i,
  input  logic [NUM_FWD*12-1:0] csr_addr_fwd_i,
  input  logic [NUM_FWD-1:0]    csr_we_fwd_i,
  output logic                  stall_fi_o,
  output logic                  stall_de_o,
  output logic                  stall_ex_o,
  output logic                  stall_mem_o,
  output logic                  stall_wb_o,
  output logic                  flush_de_o,
  output logic                  flush_ex_o,
  output logic [FWD_W-1:0]      forward_a_ex_o,
  output logic [FWD_W-1:0]      forward_b_ex_o,
  output logic [FWD_W-1:0]      forward_csr_ex_o,
  output logic                  mc_busy_o,
  output logic                  mc_done_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  hz_state_t   state, state_next;
  logic [31:0] sb_regs;
  logic        load_stall, mc_stall, hazard;
  logic        dc_active, ic_active;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^{pc_src_i[0], pc_src_reg_i[0]};

  // Iterating oldest to youngest lets the youngest matching stage win
  always_comb begin
    forward_a_ex_o   = FWD_W'(NO_FORWARD);
    forward_b_ex_o   = FWD_W'(NO_FORWARD);
    forward_csr_ex_o = FWD_W'(NO_FORWARD);
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (reg_write_fwd_i[k-1] && rs1_ex_i != 5'd0 && rd_fwd_i[(k-1)*5 +: 5] == rs1_ex_i)
        forward_a_ex_o = FWD_W'(k);
      if (reg_write_fwd_i[k-1] && rs2_ex_i != 5'd0 && rd_fwd_i[(k-1)*5 +: 5] == rs2_ex_i)
        forward_b_ex_o = FWD_W'(k);
      if (csr_we_fwd_i[k-1] && csr_addr_fwd_i[(k-1)*12 +: 12] == csr_addr_ex_i)
        forward_csr_ex_o = FWD_W'(k);
    end
  end

  hazard_unit_mc_scoreboard #(.MC_LAT(MC_LAT)) u_mc_scoreboard (
    .clk      (clk_i),
    .rst      (reset_i),
    .start    (mc_start_ex_i),
    .start_rd (rd_ex_i),
    .hold     (stall_wb_o),
    .regs     (sb_regs),
    .busy     (mc_busy_o),
    .done     (mc_done_o)
  );

  assign load_stall = (result_src_ex_i == RESULT_MEM_DATA) && (rd_ex_i != 5'd0) &&
                      ((rd_ex_i == rs1_de_i) || (rd_ex_i == rs2_de_i));
  assign mc_stall   = sb_regs[rs1_de_i] | sb_regs[rs2_de_i] | sb_regs[rd_de_i] |
                      (mc_start_ex_i && (rd_ex_i != 5'd0) &&
                       ((rd_ex_i == rs1_de_i) || (rd_ex_i == rs2_de_i)));
  assign hazard     = load_stall | mc_stall;

  // Miss stalls take effect in the entry cycle and release in the completion cycle
  assign dc_active = ((state == DC_WAIT) && !dc_ready_i) || ((state == RUN) && dc_miss_mem_i);
  assign ic_active = !dc_active && !instr_hit_fi_i;

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (dc_miss_mem_i) state_next = DC_WAIT;
               else if (!instr_hit_fi_i) state_next = IC_WAIT;
      IC_WAIT: if (instr_hit_fi_i) state_next = RUN;
      DC_WAIT: if (dc_ready_i) state_next = instr_hit_fi_i ? RUN : IC_WAIT;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= RUN;
    else         state <= state_next;
  end

  always_comb begin
    stall_fi_o  = hazard;
    stall_de_o  = hazard;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    stall_wb_o  = 1'b0;
    if (dc_active) begin
      stall_fi_o  = 1'b1;
      stall_de_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
      stall_wb_o  = 1'b1;
    end else if (ic_active) begin
      stall_fi_o  = ~pc_src_reg_i[1];
      stall_de_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
      stall_wb_o  = 1'b1;
    end
  end

  assign flush_de_o = pc_src_i[1] & ~dc_active;
  assign flush_ex_o = (pc_src_i[1] & (ic_repl_permit_i | pc_src_reg_i[1])) |
                      (hazard & ~dc_active & ~ic_active);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) stall_cycles_o <= '0;
    else if (stall_de_o && stall_cycles_o != '1) stall_cycles_o <= stall_cycles_o + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: behavioural reference model checked every cycle, plus directed literal checks.
module tb_hazard_unit_mc;

  localparam int NUM_FWD = 3;
  localparam int FWD_W   = 2;
  localparam int MC_LAT  = 8;
  localparam int CNT_W   = 6;
  localparam int MAXCNT  = (1 << CNT_W) - 1;

  logic                  clk_i, reset_i;
  logic                  instr_hit_fi_i, ic_repl_permit_i, dc_miss_mem_i, dc_ready_i;
  logic [4:0]            rs1_de_i, rs2_de_i, rd_de_i, rs1_ex_i, rs2_ex_i, rd_ex_i;
  logic [2:0]            result_src_ex_i;
  logic                  mc_start_ex_i;
  logic [11:0]           csr_addr_ex_i;
  logic [1:0]            pc_src_i, pc_src_reg_i;
  logic [NUM_FWD*5-1:0]  rd_fwd_i;
  logic [NUM_FWD-1:0]    reg_write_fwd_i;
  logic [NUM_FWD*12-1:0] csr_addr_fwd_i;
  logic [NUM_FWD-1:0]    csr_we_fwd_i;
  logic                  stall_fi_o, stall_de_o, stall_ex_o, stall_mem_o, stall_wb_o;
  logic                  flush_de_o, flush_ex_o;
  logic [FWD_W-1:0]      forward_a_ex_o, forward_b_ex_o, forward_csr_ex_o;
  logic                  mc_busy_o, mc_done_o;
  logic [CNT_W-1:0]      stall_cycles_o;

  hazard_unit_mc #(.NUM_FWD(NUM_FWD), .FWD_W(FWD_W), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .instr_hit_fi_i(instr_hit_fi_i), .ic_repl_permit_i(ic_repl_permit_i),
    .dc_miss_mem_i(dc_miss_mem_i), .dc_ready_i(dc_ready_i),
    .rs1_de_i(rs1_de_i), .rs2_de_i(rs2_de_i), .rd_de_i(rd_de_i),
    .rs1_ex_i(rs1_ex_i), .rs2_ex_i(rs2_ex_i), .rd_ex_i(rd_ex_i),
    .result_src_ex_i(result_src_ex_i), .mc_start_ex_i(mc_start_ex_i),
    .csr_addr_ex_i(csr_addr_ex_i), .pc_src_i(pc_src_i), .pc_src_reg_i(pc_src_reg_i),
    .rd_fwd_i(rd_fwd_i), .reg_write_fwd_i(reg_write_fwd_i),
    .csr_addr_fwd_i(csr_addr_fwd_i), .csr_we_fwd_i(csr_we_fwd_i),
    .stall_fi_o(stall_fi_o), .stall_de_o(stall_de_o), .stall_ex_o(stall_ex_o),
    .stall_mem_o(stall_mem_o), .stall_wb_o(stall_wb_o),
    .flush_de_o(flush_de_o), .flush_ex_o(flush_ex_o),
    .forward_a_ex_o(forward_a_ex_o), .forward_b_ex_o(forward_b_ex_o),
    .forward_csr_ex_o(forward_csr_ex_o),
    .mc_busy_o(mc_busy_o), .mc_done_o(mc_done_o), .stall_cycles_o(stall_cycles_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model state: register busy set, divider age, miss mode (0 run, 1 icache, 2 dcache)
  bit m_sb [32];
  bit m_act;
  int m_age, m_rd, m_mode, m_cnt;
  int e_fa, e_fb, e_fc, e_cnt;
  bit e_fi, e_de, e_ex, e_mem, e_wb, e_fde, e_fex, e_busy, e_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_sb[r] = 0;
    m_act = 0; m_age = 0; m_rd = 0; m_mode = 0; m_cnt = 0;
  endtask

  task automatic compute_exp();
    bit load, dep, haz, dcs, ics;
    e_fa = 0; e_fb = 0; e_fc = 0;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (e_fa == 0 && reg_write_fwd_i[k-1] && rs1_ex_i != 0 && rd_fwd_i[(k-1)*5 +: 5] == rs1_ex_i) e_fa = k;
      if (e_fb == 0 && reg_write_fwd_i[k-1] && rs2_ex_i != 0 && rd_fwd_i[(k-1)*5 +: 5] == rs2_ex_i) e_fb = k;
      if (e_fc == 0 && csr_we_fwd_i[k-1] && csr_addr_fwd_i[(k-1)*12 +: 12] == csr_addr_ex_i) e_fc = k;
    end
    load = (result_src_ex_i == 3'd1) && rd_ex_i != 0 && (rd_ex_i == rs1_de_i || rd_ex_i == rs2_de_i);
    dep  = m_sb[rs1_de_i] || m_sb[rs2_de_i] || m_sb[rd_de_i] ||
           (mc_start_ex_i && rd_ex_i != 0 && (rd_ex_i == rs1_de_i || rd_ex_i == rs2_de_i));
    haz  = load || dep;
    dcs  = (m_mode == 2 && !dc_ready_i) || (m_mode == 0 && dc_miss_mem_i);
    ics  = !dcs && !instr_hit_fi_i;
    if (dcs) begin
      e_fi = 1; e_de = 1; e_ex = 1; e_mem = 1; e_wb = 1;
    end else if (ics) begin
      e_fi = !pc_src_reg_i[1]; e_de = 1; e_ex = 1; e_mem = 1; e_wb = 1;
    end else begin
      e_fi = haz; e_de = haz; e_ex = 0; e_mem = 0; e_wb = 0;
    end
    e_fde  = pc_src_i[1] && !dcs;
    e_fex  = (pc_src_i[1] && (ic_repl_permit_i || pc_src_reg_i[1])) || (haz && !dcs && !ics);
    e_busy = mc_start_ex_i || (m_act && m_age < MC_LAT);
    e_done = m_act && m_age >= MC_LAT && !e_wb;
    e_cnt  = m_cnt;
  endtask

  task automatic model_update();
    if (reset_i) begin
      model_clear();
    end else begin
      if (e_done) begin m_sb[m_rd] = 0; m_act = 0; end
      else if (m_act) m_age++;
      if (mc_start_ex_i) begin
        m_act = 1; m_age = 1; m_rd = rd_ex_i;
        if (rd_ex_i != 0) m_sb[rd_ex_i] = 1;
      end
      case (m_mode)
        0: if (dc_miss_mem_i) m_mode = 2; else if (!instr_hit_fi_i) m_mode = 1;
        1: if (instr_hit_fi_i) m_mode = 0;
        default: if (dc_ready_i) m_mode = instr_hit_fi_i ? 0 : 1;
      endcase
      if (e_de && m_cnt < MAXCNT) m_cnt++;
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("fwd_a", 32'(forward_a_ex_o), e_fa);
      chk("fwd_b", 32'(forward_b_ex_o), e_fb);
      chk("fwd_csr", 32'(forward_csr_ex_o), e_fc);
      chk("stalls", {27'd0, stall_fi_o, stall_de_o, stall_ex_o, stall_mem_o, stall_wb_o},
          {27'd0, e_fi, e_de, e_ex, e_mem, e_wb});
      chk("flushes", {30'd0, flush_de_o, flush_ex_o}, {30'd0, e_fde, e_fex});
      chk("mc_busy", 32'(mc_busy_o), 32'(e_busy));
      chk("mc_done", 32'(mc_done_o), 32'(e_done));
      chk("stall_cycles", 32'(stall_cycles_o), e_cnt);
    end
  end

  task automatic settle();
    compute_exp();
    @(negedge clk_i);
  endtask

  task automatic advance();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic defaults();
    instr_hit_fi_i = 1; ic_repl_permit_i = 0; dc_miss_mem_i = 0; dc_ready_i = 0;
    rs1_de_i = 0; rs2_de_i = 0; rd_de_i = 0; rs1_ex_i = 0; rs2_ex_i = 0; rd_ex_i = 0;
    result_src_ex_i = 0; mc_start_ex_i = 0; csr_addr_ex_i = 0; pc_src_i = 0; pc_src_reg_i = 0;
    rd_fwd_i = '0; reg_write_fwd_i = '0; csr_addr_fwd_i = '0; csr_we_fwd_i = '0;
  endtask

  task automatic randomize_inputs();
    instr_hit_fi_i   = ($urandom_range(0, 7) != 0);
    ic_repl_permit_i = 1'($urandom_range(0, 1));
    dc_miss_mem_i    = ($urandom_range(0, 15) == 0);
    dc_ready_i       = ($urandom_range(0, 3) == 0);
    rs1_de_i = 5'($urandom_range(0, 7)); rs2_de_i = 5'($urandom_range(0, 7));
    rd_de_i  = 5'($urandom_range(0, 7)); rs1_ex_i = 5'($urandom_range(0, 7));
    rs2_ex_i = 5'($urandom_range(0, 7)); rd_ex_i  = 5'($urandom_range(0, 7));
    result_src_ex_i = 3'($urandom_range(0, 3));
    mc_start_ex_i   = !m_act && ($urandom_range(0, 5) == 0);
    csr_addr_ex_i   = 12'h300 + 12'($urandom_range(0, 1));
    pc_src_i     = 2'($urandom_range(0, 3));
    pc_src_reg_i = 2'($urandom_range(0, 3));
    for (int k = 0; k < NUM_FWD; k++) begin
      rd_fwd_i[k*5 +: 5]        = 5'($urandom_range(0, 7));
      csr_addr_fwd_i[k*12 +: 12] = 12'h300 + 12'($urandom_range(0, 1));
    end
    reg_write_fwd_i = NUM_FWD'($urandom_range(0, 7));
    csr_we_fwd_i    = NUM_FWD'($urandom_range(0, 7));
  endtask

  initial begin
    defaults();
    reset_i = 1;
    model_clear();
    chk_en = 1;
    settle();
    chk("lit_reset_stall_de", 32'(stall_de_o), 0);
    chk("lit_reset_busy", 32'(mc_busy_o), 0);
    chk("lit_reset_cnt", 32'(stall_cycles_o), 0);
    advance();
    reset_i = 0;
    settle(); advance();

    // Forwarding priority
    rd_fwd_i = {5'd9, 5'd5, 5'd5}; reg_write_fwd_i = 3'b011; rs1_ex_i = 5;
    rs2_ex_i = 9; csr_addr_ex_i = 12'h300;
    csr_addr_fwd_i = {12'h300, 12'h300, 12'h301}; csr_we_fwd_i = 3'b111;
    settle();
    chk("lit_fwd_a_youngest", 32'(forward_a_ex_o), 1);
    chk("lit_fwd_b_we_off", 32'(forward_b_ex_o), 0);
    chk("lit_fwd_csr", 32'(forward_csr_ex_o), 2);
    advance();
    rs1_ex_i = 0; reg_write_fwd_i = 3'b111;
    settle();
    chk("lit_fwd_a_x0", 32'(forward_a_ex_o), 0);
    chk("lit_fwd_b_stage3", 32'(forward_b_ex_o), 3);
    advance();
    defaults();

    // Load-use stall lasts one cycle
    result_src_ex_i = 3'd1; rd_ex_i = 7; rs2_de_i = 7;
    settle();
    chk("lit_load_stall", {29'd0, stall_fi_o, stall_de_o, flush_ex_o}, 3'b111);
    advance();
    result_src_ex_i = 0; rd_ex_i = 0;
    settle();
    chk("lit_load_release", 32'(stall_de_o), 0);
    advance();
    defaults();

    // Dependent divide: stall 0..8, done at 8, release at 9; then an independent one
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c <= 9; c++) begin
        mc_start_ex_i = (c == 0); rd_ex_i = (c == 0) ? 5'd10 : 5'd0;
        rs1_de_i = (pass == 0) ? 5'd10 : 5'd11;
        settle();
        chk("lit_div_stall", 32'(stall_de_o), 32'(pass == 0 && c <= 8));
        chk("lit_div_done", 32'(mc_done_o), 32'(c == 8));
        if (c == 1) chk("lit_div_busy", 32'(mc_busy_o), 1);
        advance();
      end
    end
    defaults();

    // Simultaneous misses, then dcache completes while icache still misses
    dc_miss_mem_i = 1; instr_hit_fi_i = 0;
    settle(); chk("lit_dc_entry", {27'd0, stall_fi_o, stall_de_o, stall_ex_o, stall_mem_o, stall_wb_o}, 5'h1f); advance();
    dc_miss_mem_i = 0;
    settle(); chk("lit_dc_hold", 32'(stall_wb_o), 1); advance();
    dc_ready_i = 1; pc_src_reg_i = 2'b10;
    settle(); chk("lit_dc_to_ic_fi", 32'(stall_fi_o), 0); chk("lit_dc_to_ic_de", 32'(stall_de_o), 1); advance();
    dc_ready_i = 0; pc_src_reg_i = 2'b00;
    settle(); chk("lit_ic_wait_fi", 32'(stall_fi_o), 1); advance();
    instr_hit_fi_i = 1;
    settle(); chk("lit_ic_exit", 32'(stall_de_o), 0); advance();
    defaults();

    // Divide completing under a dcache miss is deferred to the release cycle
    for (int c = 0; c <= 12; c++) begin
      mc_start_ex_i = (c == 0); rd_ex_i = (c == 0) ? 5'd12 : 5'd0;
      dc_miss_mem_i = (c == 2); dc_ready_i = (c == 11);
      rs1_de_i = (c == 12) ? 5'd12 : 5'd0;
      settle();
      if (c >= 8 && c <= 10) chk("lit_done_deferred", 32'(mc_done_o), 0);
      if (c == 11) chk("lit_done_release", {30'd0, mc_done_o, stall_wb_o}, 2'b10);
      if (c == 12) chk("lit_sb_cleared", {30'd0, mc_done_o, stall_de_o}, 0);
      advance();
    end
    defaults();

    // Reset in the middle of a divide aborts it
    for (int c = 0; c <= 15; c++) begin
      mc_start_ex_i = (c == 0); rd_ex_i = (c == 0) ? 5'd13 : 5'd0;
      reset_i = (c == 3);
      if (c == 3) model_clear();
      rs1_de_i = (c >= 4) ? 5'd13 : 5'd0;
      settle();
      if (c == 3) chk("lit_reset_busy_mid", 32'(mc_busy_o), 0);
      if (c >= 4) chk("lit_reset_no_done", {30'd0, mc_done_o, stall_de_o}, 0);
      advance();
    end
    defaults();

    // Stall counter saturates
    result_src_ex_i = 3'd1; rd_ex_i = 7; rs1_de_i = 7;
    for (int c = 0; c < MAXCNT + 8; c++) begin settle(); advance(); end
    settle(); chk("lit_cnt_saturated", 32'(stall_cycles_o), MAXCNT); advance();
    defaults();

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      reset_i = 0;
      if (i % 700 == 350) begin
        reset_i = 1; mc_start_ex_i = 0; model_clear();
      end
      settle(); advance();
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
